// File: rtl/laser500_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// laser500_ram_arbiter_if
// Bundles every requester-side and memory-side signal of the Laser 500 SDRAM
// byte-port arbiter. The clock (F14M) and reset (RESET_n) are not part of it.
//
//   slave  modport : the arbiter's view (requests in, acks/data/strobes out)
//   master modport : the environment's view (requesters + sdram controller)
//
// Signals:
//   dio_wr/dio_addr/dio_data, dio_ovf             download path
//   vid_req/vid_addr, vid_ack/vid_data            video fetcher
//   cpu_req/cpu_we/cpu_addr/cpu_wdata,
//   cpu_ack/cpu_rdata/cpu_wait_n                  Z80 CPU
//   mem_addr/mem_din/mem_we/mem_oe, mem_dout      sdram byte port
//   cpu_stall_cnt                                 only with ARB_STATS_EN
//
// Optional feature macro: ARB_STATS_EN
// ----------------------------------------------------------------------------
interface laser500_ram_arbiter_if #(
    parameter int AW = 25
);
    logic          dio_wr;
    logic [AW-1:0] dio_addr;
    logic [7:0]    dio_data;
    logic          dio_ovf;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [7:0]    vid_data;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          cpu_wait_n;

    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_oe;
    logic [7:0]    mem_dout;

`ifdef ARB_STATS_EN
    logic [15:0]   cpu_stall_cnt;
`endif

    modport slave (
        input  dio_wr, dio_addr, dio_data,
        output dio_ovf,
        input  vid_req, vid_addr,
        output vid_ack, vid_data,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_wait_n,
        output mem_addr, mem_din, mem_we, mem_oe,
        input  mem_dout
`ifdef ARB_STATS_EN
        , output cpu_stall_cnt
`endif
    );

    modport master (
        output dio_wr, dio_addr, dio_data,
        input  dio_ovf,
        output vid_req, vid_addr,
        input  vid_ack, vid_data,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_wait_n,
        input  mem_addr, mem_din, mem_we, mem_oe,
        output mem_dout
`ifdef ARB_STATS_EN
        , input cpu_stall_cnt
`endif
    );
endinterface

// File: rtl/laser500_ram_arbiter.sv
// ----------------------------------------------------------------------------
// laser500_ram_arbiter
// Single-port arbiter/sequencer for the SDRAM byte port shared by the download
// path, the video fetcher and the Z80. One access at a time; each strobe is
// held for ACC_CYCLES clocks, followed by a one-cycle ack slot.
//
// Ports:
//   F14M     : system clock
//   RESET_n  : asynchronous active-low reset
//   bus      : laser500_ram_arbiter_if.slave (requesters + sdram port)
//
// Parameters: ACC_CYCLES (strobe length, >=1), STARVE_LIMIT (pending-CPU
// cycles before the CPU outranks video), AW (address width).
//
// Optional feature macro: ARB_STATS_EN adds bus.cpu_stall_cnt, a saturating
// count of cycles with cpu_wait_n low.
// ----------------------------------------------------------------------------
module laser500_ram_arbiter #(
    parameter int ACC_CYCLES   = 4,
    parameter int STARVE_LIMIT = 32,
    parameter int AW           = 25
) (
    input  logic                   F14M,
    input  logic                   RESET_n,
    laser500_ram_arbiter_if.slave  bus
);
    localparam int CW = $clog2(ACC_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(ACC_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_DIO = 2'd0, OWN_VID = 2'd1, OWN_CPU = 2'd2} owner_t;

    state_t        state_r, state_s;
    owner_t        owner_r, owner_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]    mem_din_r, mem_din_s;
    logic          mem_we_r, mem_we_s, mem_oe_r, mem_oe_s;
    logic          vid_ack_r, vid_ack_s, cpu_ack_r, cpu_ack_s;
    logic [7:0]    vid_data_r, vid_data_s, cpu_rdata_r, cpu_rdata_s;
    logic          dio_full_r, dio_full_s, dio_ovf_r, dio_ovf_s;
    logic [AW-1:0] dio_addr_r, dio_addr_s;
    logic [7:0]    dio_data_r, dio_data_s;
    logic [SW-1:0] starve_r, starve_s;
    logic          boost_s, take_dio_s, take_vid_s, take_cpu_s, cpu_served_s;

    // Grant decision: the held download always wins; a starved CPU beats video.
    always_comb begin
        boost_s    = bus.cpu_req && (starve_r == STARVE_MAX);
        take_dio_s = (state_r == ST_IDLE) && dio_full_r;
        take_vid_s = (state_r == ST_IDLE) && !dio_full_r && bus.vid_req && !boost_s;
        take_cpu_s = (state_r == ST_IDLE) && !dio_full_r && bus.cpu_req && (boost_s || !bus.vid_req);
    end

    // Access sequencer: next state, strobes, captured read data and ack pulses.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        mem_addr_s  = mem_addr_r;
        mem_din_s   = mem_din_r;
        mem_we_s    = mem_we_r;
        mem_oe_s    = mem_oe_r;
        vid_ack_s   = 1'b0;
        cpu_ack_s   = 1'b0;
        vid_data_s  = vid_data_r;
        cpu_rdata_s = cpu_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (take_dio_s) begin
                    owner_s    = OWN_DIO;
                    mem_addr_s = dio_addr_r;
                    mem_din_s  = dio_data_r;
                    mem_we_s   = 1'b1;
                    mem_oe_s   = 1'b0;
                    cnt_s      = CNT_LOAD;
                    state_s    = ST_BUSY;
                end else if (take_vid_s) begin
                    owner_s    = OWN_VID;
                    mem_addr_s = bus.vid_addr;
                    mem_din_s  = 8'h00;
                    mem_we_s   = 1'b0;
                    mem_oe_s   = 1'b1;
                    cnt_s      = CNT_LOAD;
                    state_s    = ST_BUSY;
                end else if (take_cpu_s) begin
                    owner_s    = OWN_CPU;
                    mem_addr_s = bus.cpu_addr;
                    mem_din_s  = bus.cpu_wdata;
                    mem_we_s   = bus.cpu_we;
                    mem_oe_s   = ~bus.cpu_we;
                    cnt_s      = CNT_LOAD;
                    state_s    = ST_BUSY;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    // mem_dout is sampled on the last edge the strobe is still high
                    if (mem_oe_r && (owner_r == OWN_VID)) begin
                        vid_data_s = bus.mem_dout;
                    end else if (mem_oe_r && (owner_r == OWN_CPU)) begin
                        cpu_rdata_s = bus.mem_dout;
                    end else begin
                        vid_data_s = vid_data_r;
                    end
                    mem_we_s  = 1'b0;
                    mem_oe_s  = 1'b0;
                    vid_ack_s = (owner_r == OWN_VID);
                    cpu_ack_s = (owner_r == OWN_CPU);
                    state_s   = ST_DONE;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                mem_we_s = 1'b0;
                mem_oe_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // Download holding register: refills in the same cycle it is granted.
    always_comb begin
        dio_full_s = dio_full_r;
        dio_addr_s = dio_addr_r;
        dio_data_s = dio_data_r;
        dio_ovf_s  = dio_ovf_r;
        if (bus.dio_wr) begin
            if (!dio_full_r || take_dio_s) begin
                dio_full_s = 1'b1;
                dio_addr_s = bus.dio_addr;
                dio_data_s = bus.dio_data;
            end else begin
                dio_ovf_s  = 1'b1;
            end
        end else if (take_dio_s) begin
            dio_full_s = 1'b0;
        end else begin
            dio_full_s = dio_full_r;
        end
    end

    // Starvation counter: counts while the CPU waits and is not being served.
    always_comb begin
        cpu_served_s = take_cpu_s || ((state_r != ST_IDLE) && (owner_r == OWN_CPU));
        if (take_cpu_s) begin
            starve_s = {SW{1'b0}};
        end else if (bus.cpu_req && !cpu_served_s && (starve_r != STARVE_MAX)) begin
            starve_s = starve_r + SW'(1);
        end else begin
            starve_s = starve_r;
        end
    end

    // State and output registers.
    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_DIO;
            cnt_r       <= {CW{1'b0}};
            mem_addr_r  <= {AW{1'b0}};
            mem_din_r   <= 8'h00;
            mem_we_r    <= 1'b0;
            mem_oe_r    <= 1'b0;
            vid_ack_r   <= 1'b0;
            cpu_ack_r   <= 1'b0;
            vid_data_r  <= 8'h00;
            cpu_rdata_r <= 8'h00;
            dio_full_r  <= 1'b0;
            dio_addr_r  <= {AW{1'b0}};
            dio_data_r  <= 8'h00;
            dio_ovf_r   <= 1'b0;
            starve_r    <= {SW{1'b0}};
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            mem_addr_r  <= mem_addr_s;
            mem_din_r   <= mem_din_s;
            mem_we_r    <= mem_we_s;
            mem_oe_r    <= mem_oe_s;
            vid_ack_r   <= vid_ack_s;
            cpu_ack_r   <= cpu_ack_s;
            vid_data_r  <= vid_data_s;
            cpu_rdata_r <= cpu_rdata_s;
            dio_full_r  <= dio_full_s;
            dio_addr_r  <= dio_addr_s;
            dio_data_r  <= dio_data_s;
            dio_ovf_r   <= dio_ovf_s;
            starve_r    <= starve_s;
        end
    end

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_din    = mem_din_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_oe     = mem_oe_r;
    assign bus.vid_ack    = vid_ack_r;
    assign bus.vid_data   = vid_data_r;
    assign bus.cpu_ack    = cpu_ack_r;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.dio_ovf    = dio_ovf_r;
    // WAIT_n must release in the ack cycle itself, so it is combinational.
    assign bus.cpu_wait_n = ~(bus.cpu_req & ~cpu_ack_r);

`ifdef ARB_STATS_EN
    logic [15:0] stall_r;

    // CPU stall statistics: saturating count of WAIT_n-low cycles.
    always_ff @(posedge F14M or negedge RESET_n) begin
        if (!RESET_n) begin
            stall_r <= 16'h0000;
        end else if (!bus.cpu_wait_n && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign bus.cpu_stall_cnt = stall_r;
`endif
endmodule

// File: tb/tb_laser500_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_laser500_ram_arbiter
// Scoreboard bench for laser500_ram_arbiter. Stimulus pushes expected events
// (video ack, CPU ack, memory write) into a queue; a monitor branch pops and
// compares whenever the DUT presents one. The sdram is modelled as
// mem_dout = mem_addr[7:0] ^ 8'hA5 while mem_oe is high.
// Optional feature macro: ARB_STATS_EN
// ----------------------------------------------------------------------------
module tb_laser500_ram_arbiter;
    localparam int ACC = 4;

    typedef struct {
        int          kind;   // 0 video ack, 1 cpu ack, 2 memory write
        logic [24:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    ev_t  exp_q[$];
    logic [7:0] last_cpu_rd;

    laser500_ram_arbiter_if #(.AW(25)) bus ();

    laser500_ram_arbiter #(.ACC_CYCLES(ACC), .STARVE_LIMIT(32), .AW(25)) dut (
        .F14M    (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    assign bus.mem_dout = bus.mem_oe ? (bus.mem_addr[7:0] ^ 8'hA5) : 8'h00;

    // Clock generator.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] rd_model(input logic [24:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [24:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input logic [24:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_data", {24'd0, d}, {24'd0, e.data});
            if (kind == 2) chk("sb_addr", {7'd0, a}, {7'd0, e.addr});
        end
    endtask

    task automatic cpu_access(input logic we, input logic [24:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) got = 1'b1;
        end
        chk("cpu_ack_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic vid_access(input logic [24:0] a);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.vid_addr = a; bus.vid_req = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.vid_ack) got = 1'b1;
        end
        chk("vid_ack_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
    endtask

    task automatic dio_pulse(input logic [24:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.dio_wr = 1'b1; bus.dio_addr = a; bus.dio_data = d;
        @(posedge clk); #1;
        bus.dio_wr = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_mem_we"},   {31'd0, bus.mem_we}, 32'd0);
        chk({tag, "_mem_oe"},   {31'd0, bus.mem_oe}, 32'd0);
        chk({tag, "_mem_addr"}, {7'd0, bus.mem_addr}, 32'd0);
        chk({tag, "_mem_din"},  {24'd0, bus.mem_din}, 32'd0);
        chk({tag, "_acks"},     {30'd0, bus.vid_ack, bus.cpu_ack}, 32'd0);
        chk({tag, "_vid_data"}, {24'd0, bus.vid_data}, 32'd0);
        chk({tag, "_cpu_rdata"}, {24'd0, bus.cpu_rdata}, 32'd0);
        chk({tag, "_dio_ovf"},  {31'd0, bus.dio_ovf}, 32'd0);
    endtask

    initial begin
        int strobe_len;
        logic we_prev;
        n_vec = 0; n_err = 0; last_cpu_rd = 8'h00;
        strobe_len = 0; we_prev = 1'b0;
        rst_n = 1'b0;
        bus.dio_wr = 1'b0; bus.dio_addr = '0; bus.dio_data = 8'h00;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 8'h00;
        fork
            // Monitor: strobe shape checks and scoreboard pops.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    strobe_len = 0;
                    we_prev = 1'b0;
                end else begin
                    if (bus.mem_we | bus.mem_oe) begin
                        strobe_len++;
                        chk("strobe_excl", {31'd0, bus.mem_we & bus.mem_oe}, 32'd0);
                    end else if (strobe_len != 0) begin
                        chk("strobe_len", strobe_len, ACC);
                        strobe_len = 0;
                    end
                    if (bus.mem_we && !we_prev) sb_check(2, bus.mem_addr, bus.mem_din);
                    if (bus.vid_ack) sb_check(0, 25'd0, bus.vid_data);
                    if (bus.cpu_ack) sb_check(1, 25'd0, bus.cpu_rdata);
                    we_prev = bus.mem_we;
                end
            end
            // Stimulus.
            begin
                repeat (3) @(posedge clk);
                #1;
                reset_vals("rst");
                chk("rst_wait_n", {31'd0, bus.cpu_wait_n}, 32'd1);
                rst_n = 1'b1;
                @(posedge clk); #1;
                reset_vals("post_rst");

                // CPU read with WAIT_n / strobe timing.
                push(1, 25'd0, rd_model(25'h4000));
                last_cpu_rd = rd_model(25'h4000);
                fork
                    cpu_access(1'b0, 25'h4000, 8'h00);
                    begin
                        int low, oe_cnt, ack_idx;
                        low = 0; oe_cnt = 0; ack_idx = -1;
                        @(posedge clk); #1;
                        for (int i = 0; i < 12; i++) begin
                            @(negedge clk);
                            if (!bus.cpu_wait_n) low++;
                            if (bus.mem_oe) oe_cnt++;
                            if (bus.cpu_ack) ack_idx = i;
                        end
                        chk("cpu_wait_low_cycles", low, 5);
                        chk("cpu_oe_cycles", oe_cnt, 4);
                        chk("cpu_ack_cycle", ack_idx, 5);
                    end
                join
                chk("cpu_rdata_a5", {24'd0, bus.cpu_rdata}, 32'h0000_00A5);

                // Standalone video read.
                push(0, 25'd0, rd_model(25'h0155));
                vid_access(25'h0155);

                // Priority: video, then download, then CPU.
                push(0, 25'd0, rd_model(25'h0077));
                push(2, 25'h1000, 8'h11);
                push(1, 25'd0, rd_model(25'h4001));
                last_cpu_rd = rd_model(25'h4001);
                fork
                    vid_access(25'h0077);
                    cpu_access(1'b0, 25'h4001, 8'h00);
                    dio_pulse(25'h1000, 8'h11);
                join

                // Starvation: continuous video, CPU still gets through.
                for (int i = 0; i < 6; i++) push(0, 25'd0, rd_model(25'h0123));
                push(1, 25'd0, rd_model(25'h0456));
                last_cpu_rd = rd_model(25'h0456);
                @(posedge clk); #1;
                bus.vid_addr = 25'h0123; bus.vid_req = 1'b1;
                cpu_access(1'b0, 25'h0456, 8'h00);
                bus.vid_req = 1'b0;
                chk("starve_cleared", {26'd0, dut.starve_r}, 32'd0);
                repeat (8) @(posedge clk);

                // Download overflow while the CPU holds the port.
                push(1, 25'd0, rd_model(25'h4002));
                push(2, 25'h2000, 8'h22);
                last_cpu_rd = rd_model(25'h4002);
                fork
                    cpu_access(1'b0, 25'h4002, 8'h00);
                    begin
                        @(posedge clk); #1;
                        @(posedge clk); #1;
                        bus.dio_wr = 1'b1; bus.dio_addr = 25'h2000; bus.dio_data = 8'h22;
                        @(posedge clk); #1;
                        bus.dio_addr = 25'h2001; bus.dio_data = 8'h33;
                        @(posedge clk); #1;
                        bus.dio_wr = 1'b0;
                    end
                join
                repeat (10) @(posedge clk);
                #1;
                chk("dio_ovf_set", {31'd0, bus.dio_ovf}, 32'd1);

                // CPU write; cpu_rdata keeps the last read value.
                push(2, 25'h0200, 8'h3C);
                push(1, 25'd0, last_cpu_rd);
                cpu_access(1'b1, 25'h0200, 8'h3C);
                repeat (2) @(posedge clk);
                #1;
                chk("dio_ovf_sticky", {31'd0, bus.dio_ovf}, 32'd1);

                // Reset in the middle of a CPU read: strobe drops at once, no ack.
                bus.cpu_we = 1'b0; bus.cpu_addr = 25'h4003; bus.cpu_req = 1'b1;
                @(posedge clk);
                @(posedge clk); #2;
                chk("mid_oe_before_rst", {31'd0, bus.mem_oe}, 32'd1);
                rst_n = 1'b0;
                #1;
                reset_vals("mid_rst");
                bus.cpu_req = 1'b0;
                #4;
                rst_n = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                chk("mid_rst_wait_n", {31'd0, bus.cpu_wait_n}, 32'd1);

`ifdef ARB_STATS_EN
                chk("stall_cnt_zero", {16'd0, bus.cpu_stall_cnt}, 32'd0);
                for (int i = 0; i < 10; i++) begin
                    push(1, 25'd0, rd_model(25'h10 + 25'(i)));
                    cpu_access(1'b0, 25'h10 + 25'(i), 8'h00);
                end
                repeat (3) @(posedge clk);
                #1;
                chk("stall_cnt_50", {16'd0, bus.cpu_stall_cnt}, 32'd50);
`endif
                repeat (5) @(posedge clk);
                chk("scoreboard_drained", exp_q.size(), 0);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
